// File: rtl/rd_pkg.sv
// rd_pkg: shared types and constants for the restoring divider.
// Holds the controller state encoding, the default operand width and
// a helper that sizes the step counter so it can hold the value W.
package rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int RD_W  = 8;
    localparam int RD_CW = $clog2(RD_W + 1);

    function automatic int rd_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/rd_if.sv
// rd_if: request/result bundle of the restoring divider.
// The master side issues start/x/y and observes the results; the slave
// side is the divider itself. The divzero wire only exists when the
// build defines RD_DIVZERO_FLAG_EN.
interface rd_if
    import rd_pkg::*;
#(
    parameter int W = RD_W
);

    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
`ifdef RD_DIVZERO_FLAG_EN
    logic         divzero;

    modport master (output start, x, y, input quotient, remainder, done, divzero);
    modport slave  (input start, x, y, output quotient, remainder, done, divzero);
`else
    modport master (output start, x, y, input quotient, remainder, done);
    modport slave  (input start, x, y, output quotient, remainder, done);
`endif

endinterface

// File: rtl/rd_step.sv
// rd_step: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder and subtracts
// the divisor when it fits. The trial value keeps one extra bit so a
// divisor close to 2^W-1 never makes the compare wrap.
module rd_step
    import rd_pkg::*;
#(
    parameter int W = RD_W
) (
    input  logic [W-1:0] rem_acc,
    input  logic         dvd_msb,
    input  logic [W-1:0] y,
    output logic [W-1:0] new_rem,
    output logic         q_bit
);

    logic [W:0]   trial;
    logic [W-1:0] trial_sub;

    // Trial remainder, compare and restore; when the divisor fits the
    // difference is below y, so its low W bits are the whole result.
    always_comb begin
        trial     = {rem_acc, dvd_msb};
        trial_sub = trial[W-1:0] - y;
        q_bit     = (trial >= {1'b0, y});
        new_rem   = q_bit ? trial_sub : trial[W-1:0];
    end

endmodule

// File: rtl/rd.sv
// rd: sequential unsigned restoring divider, one quotient bit per clock.
// A start seen in IDLE latches x and y, W steps run in OP, and DONE
// publishes quotient/remainder with a one-cycle done pulse.
// Optional feature: define RD_DIVZERO_FLAG_EN to add the divzero output,
// which reports that the finished operation had a zero divisor.
module rd
    import rd_pkg::*;
#(
    parameter int W = RD_W
) (
    input  logic clk,
    input  logic reset,
    rd_if.slave  bus
);

    localparam int CW = rd_cnt_w(W);

    state_t        state;
    logic [W-1:0]  dvd;
    logic [W-1:0]  y_reg;
    logic [W-1:0]  rem_acc;
    logic [CW-1:0] count;
    logic [W-1:0]  step_rem;
    logic          step_q;

    rd_step #(.W(W)) u_step (
        .rem_acc (rem_acc),
        .dvd_msb (dvd[W-1]),
        .y       (y_reg),
        .new_rem (step_rem),
        .q_bit   (step_q)
    );

    // Controller, datapath registers and result registers; the dividend
    // register doubles as the quotient accumulator as bits shift in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            dvd           <= '0;
            y_reg         <= '0;
            rem_acc       <= '0;
            count         <= '0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.done      <= 1'b0;
`ifdef RD_DIVZERO_FLAG_EN
            bus.divzero   <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd     <= bus.x;
                        y_reg   <= bus.y;
                        rem_acc <= '0;
                        count   <= CW'(W);
                        state   <= OP;
                    end
                end
                OP: begin
                    dvd     <= {dvd[W-2:0], step_q};
                    rem_acc <= step_rem;
                    count   <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.quotient  <= dvd;
                    bus.remainder <= rem_acc;
                    bus.done      <= 1'b1;
`ifdef RD_DIVZERO_FLAG_EN
                    bus.divzero   <= (y_reg == '0);
`endif
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rd.sv
// tb_rd: randomized scoreboard bench for the restoring divider.
// Each issued division pushes its expected result, computed from plain
// integer division, into a queue; an independent monitor pops and
// compares whenever done is seen and checks that results hold otherwise.
module tb_rd;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    logic [W-1:0] held_q;
    logic [W-1:0] held_r;
    logic         held_dz;
    logic         prev_done;

    rd_if #(.W(W)) bus ();

    rd #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int unsigned ai;
        int unsigned bi;
        ai = a;
        bi = b;
        if (bi == 0) begin
            e.q = W'((1 << W) - 1);
            e.r = a;
        end else begin
            e.q = W'(ai / bi);
            e.r = W'(ai % bi);
        end
        e.dz = (bi == 0);
        return e;
    endfunction

    // Issues one division from a negedge, optionally holding start for a
    // second cycle and scrambling x/y mid-operation, then checks timing.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int hold, input bit scramble);
        sb.push_back(model(a, b));
        bus.start = 1'b1;
        bus.x     = a;
        bus.y     = b;
        @(posedge clk);
        for (int i = 1; i < hold; i++) @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (scramble) begin
            bus.x = W'($urandom);
            bus.y = W'($urandom);
        end
        repeat (W - (hold - 1)) @(posedge clk);
        @(negedge clk);
        checkOutput("early_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("latency_done", 32'(bus.done), 32'd1);
    endtask

    // Monitor: compares results on done and checks they hold in between.
    initial begin
        held_q    = '0;
        held_r    = '0;
        held_dz   = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held_q    = '0;
                held_r    = '0;
                held_dz   = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (bus.done) begin
                    checkOutput("done_pulse", 32'(prev_done), 32'd0);
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        checkOutput("quotient", 32'(bus.quotient), 32'(e.q));
                        checkOutput("remainder", 32'(bus.remainder), 32'(e.r));
`ifdef RD_DIVZERO_FLAG_EN
                        checkOutput("divzero", 32'(bus.divzero), 32'(e.dz));
`endif
                        held_q  = e.q;
                        held_r  = e.r;
                        held_dz = e.dz;
                    end
                end else begin
                    checkOutput("hold_quotient", 32'(bus.quotient), 32'(held_q));
                    checkOutput("hold_remainder", 32'(bus.remainder), 32'(held_r));
`ifdef RD_DIVZERO_FLAG_EN
                    checkOutput("hold_divzero", 32'(bus.divzero), 32'(held_dz));
`endif
                end
                prev_done = bus.done;
            end
        end
    end

    // Main sequence: reset, directed cases, abort by reset, random ops.
    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_quotient", 32'(bus.quotient), 32'd0);
        checkOutput("reset_remainder", 32'(bus.remainder), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);

        applyStimulus(8'd8,   8'd16, 1, 1'b0);
        applyStimulus(8'd200, 8'd7,  1, 1'b0);
        applyStimulus(8'd255, 8'd1,  1, 1'b0);
        applyStimulus(8'd0,   8'd5,  1, 1'b0);
        applyStimulus(8'd13,  8'd0,  1, 1'b0);
        applyStimulus(8'd254, 8'd255, 1, 1'b0);
        applyStimulus(8'd255, 8'd255, 1, 1'b0);
        applyStimulus(8'd8,   8'd16, 2, 1'b0);
        applyStimulus(8'd8,   8'd16, 1, 1'b1);
        applyStimulus(8'd200, 8'd7,  1, 1'b0);

        // Abort 100/3 with reset after its fourth step.
        bus.start = 1'b1;
        bus.x     = 8'd100;
        bus.y     = 8'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_quotient", 32'(bus.quotient), 32'd0);
        checkOutput("abort_remainder", 32'(bus.remainder), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        repeat (W + 3) @(negedge clk);
        checkOutput("abort_no_done", 32'(bus.done), 32'd0);
        applyStimulus(8'd100, 8'd3, 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(240, 255));
                2:       b = W'($urandom_range(1, 4));
                default: b = W'($urandom);
            endcase
            applyStimulus(a, b, int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        repeat (W + 4) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against any unforeseen stall.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
